// File: rtl/stage_sequencer.sv
// stage_sequencer
// Multicycle stage sequencer for the 16-opcode RISC core. Each instruction
// passes through IF/ID/EX/MEM/WB and takes only the stages its opcode needs.
// Stalls on the shared memory ready handshake and on an external hold. If
// memory does not respond in time, the sequencer enters a sticky fault state
// that only reset can clear.
//
// Ports:
//   clock           - system clock, rising edge
//   reset           - synchronous, active-low reset
//   instructionCode - opcode from the instruction register, valid during ID
//   memReady        - memory access complete, sampled in IF and MEM
//   hold            - freezes the sequencer for the current cycle
//   enIF/enID/enE/enMem/enWRB - one-hot stage enables
//   stateOut        - encoded state (IDLE=0 IF=1 ID=2 EX=3 MEM=4 WB=5 FAULT=7)
//   instrDone       - pulse in the final cycle of an instruction
//   retiredCount    - number of completed instructions (wraps)
//   fault           - sticky memory-timeout flag
module stage_sequencer #(
  parameter int COUNT_WIDTH  = 16,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             instructionCode,
  input  logic                   memReady,
  input  logic                   hold,
  output logic                   enIF,
  output logic                   enID,
  output logic                   enE,
  output logic                   enMem,
  output logic                   enWRB,
  output logic [2:0]             stateOut,
  output logic                   instrDone,
  output logic [COUNT_WIDTH-1:0] retiredCount,
  output logic                   fault
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IF    = 3'd1,
    ST_ID    = 3'd2,
    ST_EX    = 3'd3,
    ST_MEM   = 3'd4,
    ST_WB    = 3'd5,
    ST_FAULT = 3'd7
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [3:0]              opcode_r;
  logic [WAIT_W-1:0]       wait_r;
  logic [COUNT_WIDTH-1:0]  retired_r;
  logic                    fault_r;
  logic                    done_s;
  logic                    wait_inc_s;
  logic [4:0]              en_s;

  // Next-state, completion and wait-count decisions from the current state.
  always_comb begin
    next_state_s = state_r;
    done_s       = 1'b0;
    wait_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        next_state_s = ST_IF;
      end
      ST_IF: begin
        if (hold) begin
          next_state_s = state_r;
        end else if (memReady) begin
          next_state_s = ST_ID;
        end else if (wait_r == WAIT_LIMIT) begin
          next_state_s = ST_FAULT;
        end else begin
          wait_inc_s = 1'b1;
        end
      end
      ST_ID: begin
        if (hold) begin
          next_state_s = state_r;
        end else begin
          case (instructionCode)
            4'hC, 4'hD, 4'hE: begin
              // Jumps/calls/returns finish in decode.
              next_state_s = ST_IF;
              done_s       = 1'b1;
            end
            default: next_state_s = ST_EX;
          endcase
        end
      end
      ST_EX: begin
        if (hold) begin
          next_state_s = state_r;
        end else begin
          case (opcode_r)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: next_state_s = ST_WB;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hF: next_state_s = ST_MEM;
            default: begin
              // Branches (jump-class opcodes never reach EX).
              next_state_s = ST_IF;
              done_s       = 1'b1;
            end
          endcase
        end
      end
      ST_MEM: begin
        if (hold) begin
          next_state_s = state_r;
        end else if (memReady) begin
          case (opcode_r)
            4'h5, 4'h6, 4'h7: next_state_s = ST_WB;
            default: begin
              // Stores retire as soon as memory accepts them.
              next_state_s = ST_IF;
              done_s       = 1'b1;
            end
          endcase
        end else if (wait_r == WAIT_LIMIT) begin
          next_state_s = ST_FAULT;
        end else begin
          wait_inc_s = 1'b1;
        end
      end
      ST_WB: begin
        if (hold) begin
          next_state_s = state_r;
        end else begin
          next_state_s = ST_IF;
          done_s       = 1'b1;
        end
      end
      ST_FAULT: begin
        next_state_s = ST_FAULT;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, opcode, wait counter, retire counter and fault flag registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      opcode_r  <= 4'h0;
      wait_r    <= '0;
      retired_r <= '0;
      fault_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) begin
        wait_r <= '0;
      end else if (wait_inc_s) begin
        wait_r <= wait_r + WAIT_W'(1);
      end else begin
        wait_r <= wait_r;
      end
      if ((state_r == ST_ID) && !hold) begin
        opcode_r <= instructionCode;
      end else begin
        opcode_r <= opcode_r;
      end
      if (done_s) begin
        retired_r <= retired_r + COUNT_WIDTH'(1);
      end else begin
        retired_r <= retired_r;
      end
      fault_r <= fault_r | (next_state_s == ST_FAULT);
    end
  end

  // One-hot stage enables; silent while held, idle or faulted.
  always_comb begin
    en_s = 5'b00000;
    if (hold) begin
      en_s = 5'b00000;
    end else begin
      case (state_r)
        ST_IF:   en_s = 5'b10000;
        ST_ID:   en_s = 5'b01000;
        ST_EX:   en_s = 5'b00100;
        ST_MEM:  en_s = 5'b00010;
        ST_WB:   en_s = 5'b00001;
        default: en_s = 5'b00000;
      endcase
    end
  end

  assign enIF         = en_s[4];
  assign enID         = en_s[3];
  assign enE          = en_s[2];
  assign enMem        = en_s[1];
  assign enWRB        = en_s[0];
  assign stateOut     = state_r;
  assign instrDone    = done_s;
  assign retiredCount = retired_r;
  assign fault        = fault_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a table of per-cycle vectors plus
// hand-written sequences for the wait-limit boundary, the fault state and
// retire-counter wrap (second instance with a 4-bit counter).
module tb_stage_sequencer;

  logic        clock;
  logic        reset;
  logic [3:0]  instructionCode;
  logic        memReady;
  logic        hold;

  logic        enIF, enID, enE, enMem, enWRB;
  logic [2:0]  stateOut;
  logic        instrDone;
  logic [15:0] retiredCount;
  logic        fault;

  logic        w_enIF, w_enID, w_enE, w_enMem, w_enWRB;
  logic [2:0]  w_stateOut;
  logic        w_instrDone;
  logic [3:0]  w_retiredCount;
  logic        w_fault;

  int checks;
  int failures;

  localparam logic [4:0] E_NO  = 5'b00000;
  localparam logic [4:0] E_IF  = 5'b10000;
  localparam logic [4:0] E_ID  = 5'b01000;
  localparam logic [4:0] E_EX  = 5'b00100;
  localparam logic [4:0] E_MEM = 5'b00010;
  localparam logic [4:0] E_WB  = 5'b00001;

  stage_sequencer #(.COUNT_WIDTH(16), .MEM_WAIT_MAX(15)) dut (
    .clock(clock), .reset(reset), .instructionCode(instructionCode),
    .memReady(memReady), .hold(hold),
    .enIF(enIF), .enID(enID), .enE(enE), .enMem(enMem), .enWRB(enWRB),
    .stateOut(stateOut), .instrDone(instrDone),
    .retiredCount(retiredCount), .fault(fault)
  );

  stage_sequencer #(.COUNT_WIDTH(4), .MEM_WAIT_MAX(15)) dut_w4 (
    .clock(clock), .reset(reset), .instructionCode(instructionCode),
    .memReady(memReady), .hold(hold),
    .enIF(w_enIF), .enID(w_enID), .enE(w_enE), .enMem(w_enMem), .enWRB(w_enWRB),
    .stateOut(w_stateOut), .instrDone(w_instrDone),
    .retiredCount(w_retiredCount), .fault(w_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        hld;
    logic        mem;
    logic [3:0]  code;
    logic [2:0]  st;
    logic [4:0]  en;
    logic        done;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic hld, input logic mem,
                     input logic [3:0] code, input logic [2:0] st,
                     input logic [4:0] en, input logic done, input logic [15:0] ret);
    vec_t v;
    v.rst = rst; v.hld = hld; v.mem = mem; v.code = code;
    v.st = st; v.en = en; v.done = done; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge and let combinational outputs settle.
  task automatic step(input logic r, input logic h, input logic m, input logic [3:0] c);
    @(negedge clock);
    reset = r; hold = h; memReady = m; instructionCode = c;
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [4:0] en,
                           input logic done, input logic flt, input logic [15:0] ret);
    logic [4:0] act_en;
    act_en = {enIF, enID, enE, enMem, enWRB};
    chk({tag, "_state"}, 16'(stateOut), 16'(st));
    chk({tag, "_en"}, 16'(act_en), 16'(en));
    chk({tag, "_done"}, 16'(instrDone), 16'(done));
    chk({tag, "_fault"}, 16'(fault), 16'(flt));
    chk({tag, "_retired"}, retiredCount, ret);
    chk({tag, "_onehot"}, 16'($countones(act_en) <= 1), 16'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b0; hold = 1'b0; memReady = 1'b1; instructionCode = 4'h0;
    repeat (2) @(posedge clock);

    // Reset, then ADD (0x1): 0,1,2,3,5,1
    add(1'b0, 1'b0, 1'b1, 4'h0, 3'd0, E_NO, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd0, E_NO, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd1, E_IF, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 4'h1, 3'd2, E_ID, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd3, E_EX, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd5, E_WB, 1'b1, 16'd0);
    // LW (0x5) with three MEM wait cycles: 8 cycles total
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd1, E_IF, 1'b0, 16'd1);
    add(1'b1, 1'b0, 1'b1, 4'h5, 3'd2, E_ID, 1'b0, 16'd1);
    add(1'b1, 1'b0, 1'b0, 4'h0, 3'd3, E_EX, 1'b0, 16'd1);
    add(1'b1, 1'b0, 1'b0, 4'h0, 3'd4, E_MEM, 1'b0, 16'd1);
    add(1'b1, 1'b0, 1'b0, 4'h0, 3'd4, E_MEM, 1'b0, 16'd1);
    add(1'b1, 1'b0, 1'b0, 4'h0, 3'd4, E_MEM, 1'b0, 16'd1);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd4, E_MEM, 1'b0, 16'd1);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd5, E_WB, 1'b1, 16'd1);
    // BEQ (0xB): 3 cycles
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd1, E_IF, 1'b0, 16'd2);
    add(1'b1, 1'b0, 1'b1, 4'hB, 3'd2, E_ID, 1'b0, 16'd2);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd3, E_EX, 1'b1, 16'd2);
    // JMP (0xC): 2 cycles
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd1, E_IF, 1'b0, 16'd3);
    add(1'b1, 1'b0, 1'b1, 4'hC, 3'd2, E_ID, 1'b1, 16'd3);
    // SW (0x8): 4 cycles
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd1, E_IF, 1'b0, 16'd4);
    add(1'b1, 1'b0, 1'b1, 4'h8, 3'd2, E_ID, 1'b0, 16'd4);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd3, E_EX, 1'b0, 16'd4);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd4, E_MEM, 1'b1, 16'd4);
    // Sv (0xF): 4 cycles
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd1, E_IF, 1'b0, 16'd5);
    add(1'b1, 1'b0, 1'b1, 4'hF, 3'd2, E_ID, 1'b0, 16'd5);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd3, E_EX, 1'b0, 16'd5);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd4, E_MEM, 1'b1, 16'd5);
    // ADDI (0x4) with 2 held EX cycles: 6 cycles
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd1, E_IF, 1'b0, 16'd6);
    add(1'b1, 1'b0, 1'b1, 4'h4, 3'd2, E_ID, 1'b0, 16'd6);
    add(1'b1, 1'b1, 1'b1, 4'h0, 3'd3, E_NO, 1'b0, 16'd6);
    add(1'b1, 1'b1, 1'b1, 4'h0, 3'd3, E_NO, 1'b0, 16'd6);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd3, E_EX, 1'b0, 16'd6);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd5, E_WB, 1'b1, 16'd6);
    // hold beats memReady in IF, then LBs (0x7) reset during MEM
    add(1'b1, 1'b1, 1'b1, 4'h0, 3'd1, E_NO, 1'b0, 16'd7);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd1, E_IF, 1'b0, 16'd7);
    add(1'b1, 1'b0, 1'b1, 4'h7, 3'd2, E_ID, 1'b0, 16'd7);
    add(1'b1, 1'b0, 1'b0, 4'h0, 3'd3, E_EX, 1'b0, 16'd7);
    add(1'b1, 1'b0, 1'b0, 4'h0, 3'd4, E_MEM, 1'b0, 16'd7);
    add(1'b0, 1'b0, 1'b0, 4'h0, 3'd4, E_MEM, 1'b0, 16'd7);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd0, E_NO, 1'b0, 16'd0);
    // fetch resumes with R-type 0x0
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd1, E_IF, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd2, E_ID, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd3, E_EX, 1'b0, 16'd0);
    add(1'b1, 1'b0, 1'b1, 4'h0, 3'd5, E_WB, 1'b1, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].hld, vecs[i].mem, vecs[i].code);
      check_all($sformatf("row%0d", i), vecs[i].st, vecs[i].en, vecs[i].done, 1'b0, vecs[i].ret);
    end

    // Wait-limit boundary: 15 IF waits, memReady arrives with counter at max
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 1'b0, 1'b0, 4'h0);
      check_all($sformatf("bnd_wait%0d", k), 3'd1, E_IF, 1'b0, 1'b0, 16'd1);
    end
    step(1'b1, 1'b0, 1'b1, 4'h0);
    check_all("bnd_ready", 3'd1, E_IF, 1'b0, 1'b0, 16'd1);
    step(1'b1, 1'b0, 1'b1, 4'hD);
    check_all("bnd_id", 3'd2, E_ID, 1'b1, 1'b0, 16'd1);

    // memReady stuck low in IF: 16 IF cycles, then sticky FAULT
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 1'b0, 4'h0);
      check_all($sformatf("to_if%0d", k), 3'd1, E_IF, 1'b0, 1'b0, 16'd2);
    end
    step(1'b1, 1'b0, 1'b0, 4'h0);
    check_all("fault0", 3'd7, E_NO, 1'b0, 1'b1, 16'd2);
    step(1'b1, 1'b0, 1'b1, 4'h1);
    check_all("fault1", 3'd7, E_NO, 1'b0, 1'b1, 16'd2);
    step(1'b1, 1'b1, 1'b1, 4'h0);
    check_all("fault2", 3'd7, E_NO, 1'b0, 1'b1, 16'd2);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    check_all("fault_rst", 3'd7, E_NO, 1'b0, 1'b1, 16'd2);
    step(1'b1, 1'b0, 1'b1, 4'h0);
    check_all("fault_clr", 3'd0, E_NO, 1'b0, 1'b0, 16'd0);

    // 16 consecutive JMPs: 4-bit counter wraps 15 -> 0
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 1'b1, 4'h0);
      chk($sformatf("wrap_if%0d_state", k), 16'(stateOut), 16'd1);
      step(1'b1, 1'b0, 1'b1, 4'hC);
      chk($sformatf("wrap_id%0d_done", k), 16'(w_instrDone), 16'd1);
      chk($sformatf("wrap_id%0d_ret4", k), 16'(w_retiredCount), 16'(k % 16));
      chk($sformatf("wrap_id%0d_ret16", k), retiredCount, 16'(k));
    end
    step(1'b1, 1'b0, 1'b1, 4'h0);
    chk("wrap_final_ret4", 16'(w_retiredCount), 16'd0);
    chk("wrap_final_ret16", retiredCount, 16'd16);
    chk("wrap_final_state", 16'(w_stateOut), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multicycle stage sequencer for the 16-opcode RISC core.
- Walks each instruction through IF/ID/EX/MEM/WB, taking only the stages its opcode needs.
- Drives one-hot stage enables to the datapath and to the control-signal decoder.
- Stalls on a shared memory ready handshake and on an external hold; a memory timeout moves it to a sticky fault state.

Parameters:
- COUNT_WIDTH, 16, width of the retired-instruction counter.
- MEM_WAIT_MAX, 15, maximum consecutive wait cycles on memReady before fault (minimum 1).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- instructionCode  input  4  opcode from the instruction register; valid during ID.
- memReady  input  1  memory access complete, sampled in IF and MEM.
- hold  input  1  freezes the sequencer for the current cycle.
- enIF / enID / enE / enMem / enWRB  output  1 each  one-hot stage enables.
- stateOut  output  3  encoded state: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, FAULT=7.
- instrDone  output  1  one-cycle pulse in the final cycle of an instruction.
- retiredCount  output  COUNT_WIDTH  number of completed instructions.
- fault  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, latched opcode=0, wait counter=0, retiredCount=0, fault=0.
  - All enables and instrDone are 0 while in IDLE.
- Enables are combinational decodes of the registered state, gated low when hold==1 or state is IDLE/FAULT.
- IDLE -> IF unconditionally on the next edge.
- IF:
  - Stays in IF while memReady==0.
  - Moves to ID on the edge where memReady==1.
- ID:
  - Latches instructionCode into the opcode register on exit.
  - Next state depends on instructionCode: 0xC, 0xD or 0xE -> IF; all other opcodes -> EX.
- EX, next state from the latched opcode:
  - 0x0-0x4 (R-type, ANDI, ADDI) -> WB.
  - 0x5-0x8 (LW, LBu, LBs, SW) and 0xF (Sv) -> MEM.
  - 0x9-0xB (branches) -> IF.
- MEM:
  - Waits for memReady==1.
  - Then goes to WB for 0x5-0x7, or to IF for 0x8 and 0xF.
- WB -> IF.
- Resulting cycle counts with no waits or holds:
  - ALU ops: 4 cycles.
  - Loads: 5 cycles.
  - SW, Sv: 4 cycles.
  - Branches: 3 cycles.
  - JMP, CALL, RET: 2 cycles.
- instrDone asserts in the terminating cycle, provided the cycle is not held and any required memReady is present:
  - ID for 0xC-0xE, EX for branches, MEM for SW/Sv, WB otherwise.
  - retiredCount increments on that edge and wraps from all-ones to 0.
- hold==1:
  - State, opcode register and wait counter are all frozen.
  - Enables and instrDone are 0.
  - hold takes priority over memReady in the same cycle.
  - hold has no effect in IDLE or FAULT.
- Wait counter:
  - Increments on each un-held cycle in IF or MEM with memReady==0.
  - Clears on any state change.
  - If the counter equals MEM_WAIT_MAX and memReady is still 0, the next state is FAULT.
  - memReady==1 on that same cycle completes the access normally, with no fault.
- FAULT:
  - fault=1, all enables 0.
  - Exited only by reset.
- reset==0 mid-instruction returns the sequencer to IDLE at that edge; retiredCount clears and any partial instruction is not counted.
- Invariant: at most one enable is high in any cycle.

Test Plan:
- Reset release, memReady=1, ADD (0x1): stateOut sequence 0,1,2,3,5,1; enIF,enID,enE,enWRB each high for exactly 1 cycle; instrDone in the WB cycle; retiredCount=1.
- LW (0x5), memReady low for 3 MEM cycles: enMem high for 4 cycles; total 8 cycles; fault=0; retiredCount=1.
- Sequence BEQ (0xB), JMP (0xC), SW (0x8), Sv (0xF), memReady=1: durations 3, 2, 4 and 4 cycles; WB never entered; retiredCount=4.
- hold=1 for 2 cycles during EX of ADDI (0x4): all enables 0 in those cycles; state stays 3; instruction completes in 6 cycles.
- memReady stuck at 0 in IF with MEM_WAIT_MAX=15: FAULT (stateOut=7, fault=1) entered after 16 IF cycles; stays there until reset, with enables 0.
- Reset asserted during MEM of LBs (0x7): next stateOut=0, retiredCount=0; normal fetch resumes after release.
- COUNT_WIDTH=4 with 16 consecutive JMPs: retiredCount wraps from 15 to 0.
